guess_scorer: RTL and testbench
===============================

# guess_scorer

Upstream scoring stage of the number-guessing game. Collects a 4-digit guess one BCD digit at a time, compares it against the 4-digit secret over 16 sequential cycles, and produces the A count (right digit, right place) and the B count (right digit, wrong place). These counts feed the A/B seven-segment display stage. The block also tracks the attempt count and flags a win.

## Interface
- NUM_DIGITS, 4: digits per guess and per secret; fixed, not for resizing.
- MAX_ATTEMPTS, 15: saturation value of the attempt counter.

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- digit_in  in  4  BCD digit from keypad/switch stage
- digit_valid  in  1  one-cycle strobe, already debounced; qualifies digit_in
- new_game  in  1  one-cycle strobe; clears guess, counts, attempts, win
- secret  in  16  four BCD digits, [15:12] = position 0 (leftmost); all digits distinct (upstream guarantee)
- guess  out  16  digits entered so far, same packing as secret
- digit_count  out  3  number of digits held in guess, 0..4
- a_count  out  4  A result, 0..4; drives the display stage in_A
- b_count  out  4  B result, 0..4; drives the display stage in_B
- score_valid  out  1  one-cycle pulse when a_count/b_count update
- busy  out  1  high while in SCORE or REPORT
- attempts  out  4  guesses scored since reset/new_game, saturates at MAX_ATTEMPTS
- win  out  1  sticky; set when a_count==4

## Operation
- States: COLLECT, SCORE, REPORT.
- COLLECT:
  - digit_valid with digit_in ≤ 9 that differs from every digit already held: store the digit at position digit_count; digit_count increments.
  - Digit > 9 or a duplicate: ignored; no state change.
  - If win=1, all digits are ignored until new_game.
  - Acceptance of the 4th digit: latch secret into a shadow register, clear the A/B accumulators, reset pair index to 0, go to SCORE.
- SCORE:
  - One pair (i, j) per cycle, index 0..15, with i = index[3:2] and j = index[1:0].
  - If guess[i]==secret_shadow[j]: i==j increments the A accumulator, otherwise the B accumulator.
  - After index 15, go to REPORT.
  - digit_valid is ignored in SCORE and REPORT.
- REPORT (one cycle):
  - a_count/b_count ← accumulators; score_valid=1.
  - attempts ← attempts+1, saturating at 15.
  - win ← 1 if the A result is 4.
  - Clear guess and digit_count to 0, go to COLLECT.
- Width rule: with distinct guess and secret digits, A+B ≤ 4, so 3-bit accumulators zero-extend to the 4-bit outputs.
- new_game:
  - Valid in any state; returns to COLLECT.
  - Zeroes guess, digit_count, a_count, b_count, attempts and win, and drops any in-flight score.
  - Takes priority over a simultaneous digit_valid (the digit is dropped).
- Changes to secret during SCORE do not affect the result (shadow copy).

## Timing
- Reset (async assert, sync release): state=COLLECT, and guess, digit_count, a_count, b_count, attempts, score_valid, win, busy and the internal index are all 0.
- Latency: 4th digit accepted at edge E0; SCORE occupies E1..E16; REPORT is the cycle after E16; outputs update and score_valid goes high after E17. This gives 17 cycles from 4th-digit acceptance to score_valid.
- busy is high from after E0 through the REPORT cycle.
- a_count/b_count hold until the next REPORT or new_game.
- score_valid is never high for two consecutive cycles.
- Reset mid-SCORE: all outputs return to reset values immediately; no score_valid.

## Structure
- Shared package guess_pkg: state enum (COLLECT/SCORE/REPORT), NUM_DIGITS, BCD digit typedef, MAX_DIGIT=9 constant. The display stage uses the same digit typedef.
- Single module; no sub-module. The duplicate check is a 4-way compare inline.

## Test plan
- Secret 1234, enter 1,2,3,4 → 17 cycles later a_count=4, b_count=0, score_valid pulse, win=1, attempts=1.
- Secret 1234, enter 4,3,2,1 → a=0, b=4, win=0. Then enter 5,1,9,3 → a=0, b=2, attempts=2.
- Secret 1234, enter 1,1,0xA,5,6,7 → second 1 and 0xA ignored; guess=1567, a=1, b=0.
- Secret 1234, complete a guess, toggle secret to 5678 during SCORE → result still computed against 1234. Digits strobed during busy are ignored, and digit_count stays 0.
- 16 scored non-winning guesses → attempts stays at 15. Then new_game → attempts=0, a=b=0, win=0.
- Assert rst_n low at SCORE index 7 → all outputs 0 asynchronously, no score_valid. After release, a fresh guess scores correctly.

Source files
------------

// File: rtl/guess_pkg.sv
// Shared types and constants for the number-guessing game datapath.
// Also used by the A/B display stage for its digit type.
package guess_pkg;

    localparam int NUM_DIGITS   = 4;
    localparam int MAX_ATTEMPTS = 15;

    typedef logic [3:0] digit_t;
    localparam digit_t MAX_DIGIT = 4'd9;

    // Element 0 sits in the most significant nibble (leftmost position).
    typedef digit_t [0:NUM_DIGITS-1] code_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCORE   = 2'd1,
        REPORT  = 2'd2
    } state_e;

endpackage

// File: rtl/guess_scorer_if.sv
// Keypad-side bus of the guess scorer: digit entry, secret and score results.
// The master drives entry and secret; the slave (scorer) drives the results.
interface guess_scorer_if;
    import guess_pkg::*;

    digit_t     digit_in;
    logic       digit_valid;
    logic       new_game;
    code_t      secret;
    code_t      guess;
    logic [2:0] digit_count;
    logic [3:0] a_count;
    logic [3:0] b_count;
    logic       score_valid;
    logic       busy;
    logic [3:0] attempts;
    logic       win;

    modport master (
        output digit_in, digit_valid, new_game, secret,
        input  guess, digit_count, a_count, b_count, score_valid, busy, attempts, win
    );

    modport slave (
        input  digit_in, digit_valid, new_game, secret,
        output guess, digit_count, a_count, b_count, score_valid, busy, attempts, win
    );

endinterface

// File: rtl/guess_scorer.sv
// Collects a 4-digit guess, scores it against a shadowed secret one digit pair
// per cycle (16 cycles), then reports A/B counts, attempts and a sticky win.
module guess_scorer
    import guess_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    guess_scorer_if.slave  bus
);

    state_e     state_q, state_d;
    code_t      guess_q, guess_d;
    code_t      shadow_q, shadow_d;
    logic [2:0] count_q, count_d;
    logic [3:0] idx_q, idx_d;
    logic [2:0] acc_a_q, acc_a_d;
    logic [2:0] acc_b_q, acc_b_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] attempts_q, attempts_d;
    logic       win_q, win_d;
    logic       score_valid_q, score_valid_d;
    logic       busy;
    logic       dup;
    logic       accept;
    logic       match;

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        dup = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (3'(k) < count_q && guess_q[k] == bus.digit_in) dup = 1'b1;
        end
    end

    assign accept = (state_q == COLLECT) && bus.digit_valid && !bus.new_game && !win_q
                    && (bus.digit_in <= MAX_DIGIT) && !dup;
    assign match  = (guess_q[idx_q[3:2]] == shadow_q[idx_q[1:0]]);

    // State register
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= COLLECT;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.new_game) begin
            state_d = COLLECT;
        end else begin
            unique case (state_q)
                COLLECT: if (accept && count_q == 3'(NUM_DIGITS - 1)) state_d = SCORE;
                SCORE:   if (idx_q == 4'hF) state_d = REPORT;
                REPORT:  state_d = COLLECT;
                default: state_d = COLLECT;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy = (state_q == SCORE) || (state_q == REPORT);
    end

    // Datapath next values; new_game overrides everything, including a same-cycle digit.
    always_comb begin
        guess_d       = guess_q;
        shadow_d      = shadow_q;
        count_d       = count_q;
        idx_d         = idx_q;
        acc_a_d       = acc_a_q;
        acc_b_d       = acc_b_q;
        a_d           = a_q;
        b_d           = b_q;
        attempts_d    = attempts_q;
        win_d         = win_q;
        score_valid_d = 1'b0;
        if (bus.new_game) begin
            guess_d    = '0;
            count_d    = '0;
            idx_d      = '0;
            acc_a_d    = '0;
            acc_b_d    = '0;
            a_d        = '0;
            b_d        = '0;
            attempts_d = '0;
            win_d      = 1'b0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (accept) begin
                        guess_d[count_q[1:0]] = bus.digit_in;
                        count_d               = count_q + 3'd1;
                        if (count_q == 3'(NUM_DIGITS - 1)) begin
                            shadow_d = bus.secret;
                            idx_d    = '0;
                            acc_a_d  = '0;
                            acc_b_d  = '0;
                        end
                    end
                end
                SCORE: begin
                    idx_d = idx_q + 4'd1;
                    if (match) begin
                        if (idx_q[3:2] == idx_q[1:0]) acc_a_d = acc_a_q + 3'd1;
                        else                          acc_b_d = acc_b_q + 3'd1;
                    end
                end
                REPORT: begin
                    a_d           = {1'b0, acc_a_q};
                    b_d           = {1'b0, acc_b_q};
                    score_valid_d = 1'b1;
                    if (attempts_q != 4'(MAX_ATTEMPTS)) attempts_d = attempts_q + 4'd1;
                    win_d         = win_q | (acc_a_q == 3'(NUM_DIGITS));
                    guess_d       = '0;
                    count_d       = '0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the shadow secret is reset along with everything else; it is only a 16-bit register, not a memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guess_q       <= '0;
            shadow_q      <= '0;
            count_q       <= '0;
            idx_q         <= '0;
            acc_a_q       <= '0;
            acc_b_q       <= '0;
            a_q           <= '0;
            b_q           <= '0;
            attempts_q    <= '0;
            win_q         <= 1'b0;
            score_valid_q <= 1'b0;
        end else begin
            guess_q       <= guess_d;
            shadow_q      <= shadow_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            acc_a_q       <= acc_a_d;
            acc_b_q       <= acc_b_d;
            a_q           <= a_d;
            b_q           <= b_d;
            attempts_q    <= attempts_d;
            win_q         <= win_d;
            score_valid_q <= score_valid_d;
        end
    end

    assign bus.guess       = guess_q;
    assign bus.digit_count = count_q;
    assign bus.a_count     = a_q;
    assign bus.b_count     = b_q;
    assign bus.score_valid = score_valid_q;
    assign bus.busy        = busy;
    assign bus.attempts    = attempts_q;
    assign bus.win         = win_q;

endmodule

// File: tb/tb_guess_scorer.sv
// Self-checking bench for guess_scorer: directed game scenarios plus random
// rounds, all checked against a positional A/B scoring model.
module tb_guess_scorer;
    import guess_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    guess_scorer_if bus ();

    guess_scorer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_guess[$];
    int          m_att      = 0;
    bit          m_win      = 1'b0;
    bit          m_scoring  = 1'b0;
    logic [15:0] m_secret   = '0;
    int          accept_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_guess();
        logic [15:0] v = '0;
        foreach (m_guess[p]) v |= 16'(m_guess[p]) << (12 - 4 * p);
        return v;
    endfunction

    function automatic int sdig(input logic [15:0] s, input int j);
        return int'((s >> (12 - 4 * j)) & 16'hF);
    endfunction

    function automatic logic [15:0] rand_code();
        int d[10];
        int j, t;
        for (int i = 0; i < 10; i++) d[i] = i;
        for (int i = 9; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = d[i]; d[i] = d[j]; d[j] = t;
        end
        return 16'((d[0] << 12) | (d[1] << 8) | (d[2] << 4) | d[3]);
    endfunction

    task automatic model_clear();
        m_guess.delete();
        m_att     = 0;
        m_win     = 1'b0;
        m_scoring = 1'b0;
    endtask

    task automatic send_digit(input int d);
        bit dupl = 1'b0;
        bus.digit_in    = 4'(d);
        bus.digit_valid = 1'b1;
        @(posedge clk); #1;
        bus.digit_valid = 1'b0;
        foreach (m_guess[p]) if (m_guess[p] == d) dupl = 1'b1;
        if (!m_scoring && !m_win && d <= 9 && !dupl) begin
            m_guess.push_back(d);
            if (m_guess.size() == NUM_DIGITS) begin
                m_scoring  = 1'b1;
                m_secret   = bus.secret;
                accept_cyc = cyc;
                check("busy_after_accept", 32'(bus.busy), 32'd1);
            end
        end
        check("digit_count", 32'(bus.digit_count), 32'(m_guess.size()));
        check("guess", 32'(bus.guess), 32'(model_guess()));
    endtask

    task automatic wait_score(input string tag);
        int ea = 0, eb = 0, lim = 0;
        bit busy_all = 1'b1;
        while (bus.score_valid !== 1'b1 && lim < 40) begin
            if (bus.busy !== 1'b1) busy_all = 1'b0;
            @(posedge clk); #1;
            lim++;
        end
        for (int i = 0; i < NUM_DIGITS; i++)
            for (int j = 0; j < NUM_DIGITS; j++)
                if (m_guess[i] == sdig(m_secret, j)) begin
                    if (i == j) ea++;
                    else        eb++;
                end
        m_att     = (m_att < MAX_ATTEMPTS) ? m_att + 1 : MAX_ATTEMPTS;
        if (ea == NUM_DIGITS) m_win = 1'b1;
        m_guess.delete();
        m_scoring = 1'b0;
        check({tag, "_latency"}, 32'(cyc - accept_cyc), 32'd17);
        check({tag, "_busy_held"}, 32'(busy_all), 32'd1);
        check({tag, "_a"}, 32'(bus.a_count), 32'(ea));
        check({tag, "_b"}, 32'(bus.b_count), 32'(eb));
        check({tag, "_attempts"}, 32'(bus.attempts), 32'(m_att));
        check({tag, "_win"}, 32'(bus.win), 32'(m_win));
        check({tag, "_guess_clr"}, 32'(bus.guess), 32'd0);
        check({tag, "_count_clr"}, 32'(bus.digit_count), 32'd0);
        check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        check({tag, "_pulse_one"}, 32'(bus.score_valid), 32'd0);
    endtask

    task automatic send_code(input logic [15:0] c, input string tag);
        for (int p = 0; p < NUM_DIGITS; p++) send_digit(sdig(c, p));
        wait_score(tag);
    endtask

    task automatic do_new_game();
        bus.new_game = 1'b1;
        @(posedge clk); #1;
        bus.new_game = 1'b0;
        model_clear();
        check("ng_attempts", 32'(bus.attempts), 32'd0);
        check("ng_a", 32'(bus.a_count), 32'd0);
        check("ng_b", 32'(bus.b_count), 32'd0);
        check("ng_win", 32'(bus.win), 32'd0);
        check("ng_count", 32'(bus.digit_count), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_guess"}, 32'(bus.guess), 32'd0);
        check({tag, "_count"}, 32'(bus.digit_count), 32'd0);
        check({tag, "_a"}, 32'(bus.a_count), 32'd0);
        check({tag, "_b"}, 32'(bus.b_count), 32'd0);
        check({tag, "_attempts"}, 32'(bus.attempts), 32'd0);
        check({tag, "_sv"}, 32'(bus.score_valid), 32'd0);
        check({tag, "_win"}, 32'(bus.win), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bit          sv_seen;
        logic [15:0] c;
        int          tries;

        bus.digit_in    = '0;
        bus.digit_valid = 1'b0;
        bus.new_game    = 1'b0;
        bus.secret      = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Exact guess wins on the first attempt
        send_code(16'h1234, "win");
        check("win_a4", 32'(bus.a_count), 32'd4);
        check("win_flag", 32'(bus.win), 32'd1);
        send_digit(5);
        check("win_blocks_digits", 32'(bus.digit_count), 32'd0);
        do_new_game();

        // Full permutation, then partial overlap
        send_code(16'h4321, "perm");
        check("perm_b4", 32'(bus.b_count), 32'd4);
        send_code(16'h5193, "part");
        check("part_b2", 32'(bus.b_count), 32'd2);
        check("part_att2", 32'(bus.attempts), 32'd2);

        // Duplicate and non-BCD digits are dropped
        do_new_game();
        send_digit(1); send_digit(1); send_digit(10);
        check("dup_ignored", 32'(bus.digit_count), 32'd1);
        send_digit(5); send_digit(6); send_digit(7);
        check("guess_1567", 32'(bus.guess), 32'h1567);
        wait_score("filt");
        check("filt_a1", 32'(bus.a_count), 32'd1);

        // Secret changes and digits during SCORE have no effect
        send_digit(1); send_digit(2); send_digit(4); send_digit(3);
        bus.secret = 16'h5678;
        send_digit(5); send_digit(6);
        wait_score("shadow");
        check("shadow_a2", 32'(bus.a_count), 32'd2);
        check("shadow_b2", 32'(bus.b_count), 32'd2);
        bus.secret = 16'h1234;

        // Asynchronous reset in the middle of scoring
        send_digit(1); send_digit(2); send_digit(3); send_digit(5);
        repeat (7) @(posedge clk);
        #1;
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all_zero("async_rst");
        sv_seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.score_valid !== 1'b0) sv_seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.score_valid !== 1'b0) sv_seen = 1'b1;
        end
        check("rst_no_score", 32'(sv_seen), 32'd0);
        send_code(16'h4321, "post_rst");

        // Random rounds against the model
        for (int r = 0; r < 12; r++) begin
            if (m_win) do_new_game();
            bus.secret = rand_code();
            tries = 0;
            while (!m_scoring && tries < 40) begin
                send_digit(int'($urandom_range(0, 15)));
                tries++;
            end
            if (m_scoring) wait_score("rand");
        end

        // Attempt counter saturation, then new_game
        do_new_game();
        bus.secret = 16'h1234;
        for (int g = 0; g < 16; g++) begin
            do c = rand_code(); while (c == 16'h1234);
            send_code(c, "sat");
        end
        check("sat_15", 32'(bus.attempts), 32'd15);
        do_new_game();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
